wave_display_reader: RTL and testbench

- Read side of the double-buffered 512x8 waveform RAM; the capture block fills the other half.
- Takes VGA raster coordinates and issues RAM read addresses into the half selected by read_index.
- Compares returned samples against the raster row and emits a per-pixel waveform hit.
- Drives wave_display_idle so the buffer flip happens only between frames.

---
 rtl/wave_display_reader_pkg.sv | 24 ++
 rtl/wave_display_reader_if.sv | 38 +++
 rtl/wave_display_reader_segment_compare.sv | 20 ++
 rtl/wave_display_reader.sv | 126 ++++++++++++
 tb/tb_wave_display_reader.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/wave_display_reader_pkg.sv
// Shared constants and types for the waveform display reader and its capture-side peers.
package wave_display_reader_pkg;

  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int ADDR_W   = 9;
  localparam int SAMPLE_W = 8;

  localparam int REGION_X_LO     = 512;
  localparam int REGION_X_HI     = 1023;
  localparam int REGION_Y_HI     = 511;
  localparam int SAMPLES_PER_BUF = 256;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Waveform occupies the right half of the top 512 rows of the raster.
  function automatic logic in_region(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x >= X_W'(REGION_X_LO)) && (x <= X_W'(REGION_X_HI)) && (y <= Y_W'(REGION_Y_HI));
  endfunction

endpackage

// File: rtl/wave_display_reader_if.sv
// Raster-in / RAM-read / pixel-out bundle for wave_display_reader.
// grid_on exists only when WAVE_DISPLAY_GRID_EN is defined.
interface wave_display_reader_if #(
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int ADDR_W   = 9,
  parameter int SAMPLE_W = 8
);
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic                valid;
  logic                read_index;
  logic [ADDR_W-1:0]   read_address;
  logic [SAMPLE_W-1:0] read_value;
  logic                valid_pixel;
  logic                pixel_on;
  logic                wave_display_idle;
`ifdef WAVE_DISPLAY_GRID_EN
  logic                grid_on;
`endif

  modport master (
    output x, y, valid, read_index, read_value,
    input  read_address, valid_pixel, pixel_on, wave_display_idle
`ifdef WAVE_DISPLAY_GRID_EN
    , input grid_on
`endif
  );

  modport slave (
    input  x, y, valid, read_index, read_value,
    output read_address, valid_pixel, pixel_on, wave_display_idle
`ifdef WAVE_DISPLAY_GRID_EN
    , output grid_on
`endif
  );

endinterface

// File: rtl/wave_display_reader_segment_compare.sv
// Combinational check that a row lies on the vertical segment joining two samples.
module wave_segment_compare #(
  parameter int SAMPLE_W = 8
) (
  input  logic [SAMPLE_W-1:0] prev_sample,
  input  logic [SAMPLE_W-1:0] cur_sample,
  input  logic [SAMPLE_W-1:0] row,
  output logic                hit
);

  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] hi;

  always_comb begin
    lo  = (prev_sample < cur_sample) ? prev_sample : cur_sample;
    hi  = (prev_sample < cur_sample) ? cur_sample  : prev_sample;
    hit = (row >= lo) && (row <= hi);
  end

endmodule

// File: rtl/wave_display_reader.sv
// Display-side reader of the double-buffered waveform RAM: two-stage raster pipeline
// plus frame FSM. Optional grid overlay output under WAVE_DISPLAY_GRID_EN.
module wave_display_reader
  import wave_display_reader_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  wave_display_reader_if.slave bus
);

  state_e              state_q, state_d;
  logic                frame_index_q, frame_index_d;
  logic                idle_q, idle_d;

  logic [8:0]          x1_q, x1_d;
  logic [7:0]          row1_q, row1_d;
  logic                valid1_q, valid1_d;
  logic                in_region1_q, in_region1_d;
  logic [SAMPLE_W-1:0] prev_sample_q, prev_sample_d;
  logic [SAMPLE_W-1:0] cur_sample_q, cur_sample_d;
  logic                valid_pixel_q, valid_pixel_d;
  logic                pixel_on_q, pixel_on_d;
  logic                seg_hit;
`ifdef WAVE_DISPLAY_GRID_EN
  logic                grid1_q, grid1_d;
  logic                grid_on_q, grid_on_d;
`endif

  assign bus.read_address = {frame_index_q, bus.x[8:1]};

  // The buffer half is frozen at frame start so a flip never tears a frame.
  always_comb begin
    state_d       = state_q;
    frame_index_d = frame_index_q;
    if (bus.valid) begin
      if (bus.x == '0 && bus.y == '0) begin
        state_d       = ACTIVE;
        frame_index_d = bus.read_index;
      end else if (state_q == ACTIVE && bus.x == X_W'(REGION_X_HI) &&
                   bus.y == Y_W'(REGION_Y_HI)) begin
        state_d = IDLE;
      end
    end
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      frame_index_q <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      frame_index_q <= frame_index_d;
      idle_q        <= idle_d;
    end
  end

  // RAM data lands while the coordinate sits in S1; a new sample starts on even x.
  always_comb begin
    x1_d          = bus.x[8:0];
    row1_d        = bus.y[8:1];
    valid1_d      = bus.valid;
    in_region1_d  = in_region(bus.x, bus.y);
    prev_sample_d = prev_sample_q;
    cur_sample_d  = cur_sample_q;
    if (valid1_q && in_region1_q && !x1_q[0]) begin
      cur_sample_d  = bus.read_value;
      prev_sample_d = (x1_q[8:1] == '0) ? bus.read_value : cur_sample_q;
    end
  end

  wave_segment_compare #(.SAMPLE_W(SAMPLE_W)) u_seg (
    .prev_sample (prev_sample_d),
    .cur_sample  (cur_sample_d),
    .row         (row1_q),
    .hit         (seg_hit)
  );

  always_comb begin
    valid_pixel_d = valid1_q;
    pixel_on_d    = valid1_q && in_region1_q && seg_hit;
`ifdef WAVE_DISPLAY_GRID_EN
    grid1_d       = in_region(bus.x, bus.y) && (bus.x[5:0] == '0 || bus.y[5:0] == '0);
    grid_on_d     = valid1_q && grid1_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q          <= '0;
      row1_q        <= '0;
      valid1_q      <= 1'b0;
      in_region1_q  <= 1'b0;
      prev_sample_q <= '0;
      cur_sample_q  <= '0;
      valid_pixel_q <= 1'b0;
      pixel_on_q    <= 1'b0;
`ifdef WAVE_DISPLAY_GRID_EN
      grid1_q       <= 1'b0;
      grid_on_q     <= 1'b0;
`endif
    end else begin
      x1_q          <= x1_d;
      row1_q        <= row1_d;
      valid1_q      <= valid1_d;
      in_region1_q  <= in_region1_d;
      prev_sample_q <= prev_sample_d;
      cur_sample_q  <= cur_sample_d;
      valid_pixel_q <= valid_pixel_d;
      pixel_on_q    <= pixel_on_d;
`ifdef WAVE_DISPLAY_GRID_EN
      grid1_q       <= grid1_d;
      grid_on_q     <= grid_on_d;
`endif
    end
  end

  assign bus.valid_pixel       = valid_pixel_q;
  assign bus.pixel_on          = pixel_on_q;
  assign bus.wave_display_idle = idle_q;
`ifdef WAVE_DISPLAY_GRID_EN
  assign bus.grid_on           = grid_on_q;
`endif

endmodule

// File: tb/tb_wave_display_reader.sv
// Self-checking bench for wave_display_reader: directed scans plus random raster traffic
// against a sample-sequence reference model. Grid checks only under WAVE_DISPLAY_GRID_EN.
`timescale 1ns/1ps
module tb_wave_display_reader;
  import wave_display_reader_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wave_display_reader_if bus ();

  wave_display_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:511];
  always @(posedge clk) bus.read_value <= mem[bus.read_address];

  typedef struct packed {
    logic v;
    logic p;
    logic g;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  bit   m_active;
  bit   m_frame;
  int   m_prev;
  int   m_cur;
  exp_t e_last;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_frame  = 1'b0;
    m_prev   = 0;
    m_cur    = 0;
    e_last   = '0;
  endtask

  // One raster coordinate per clock; outputs after the edge belong to the previous coordinate.
  task automatic apply_stimulus(input int xi, input int yi, input bit vi, input bit ri);
    exp_t e_now;
    bit   inr;
    int   idx, s, row, lo, hi;
    @(negedge clk);
    bus.x          = xi[10:0];
    bus.y          = yi[9:0];
    bus.valid      = vi;
    bus.read_index = ri;
    #1;
    check_output("read_address", 32'(bus.read_address),
                 32'(int'(m_frame) * SAMPLES_PER_BUF + (xi / 2) % SAMPLES_PER_BUF));
    inr = vi && xi >= 512 && xi <= 1023 && yi <= 511;
    if (inr && (xi % 2 == 0)) begin
      idx    = (xi - 512) / 2;
      s      = int'(mem[int'(m_frame) * SAMPLES_PER_BUF + idx]);
      m_prev = (idx == 0) ? s : m_cur;
      m_cur  = s;
    end
    row     = (yi / 2) % 256;
    lo      = (m_prev < m_cur) ? m_prev : m_cur;
    hi      = (m_prev < m_cur) ? m_cur : m_prev;
    e_now.v = vi;
    e_now.p = inr && row >= lo && row <= hi;
    e_now.g = inr && ((xi % 64 == 0) || (yi % 64 == 0));
    if (vi) begin
      if (xi == 0 && yi == 0) begin
        m_active = 1'b1;
        m_frame  = ri;
      end else if (m_active && xi == 1023 && yi == 511) begin
        m_active = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_output("valid_pixel", 32'(bus.valid_pixel), 32'(e_last.v));
    check_output("pixel_on", 32'(bus.pixel_on), 32'(e_last.p));
`ifdef WAVE_DISPLAY_GRID_EN
    check_output("grid_on", 32'(bus.grid_on), 32'(e_last.g));
`endif
    check_output("idle", 32'(bus.wave_display_idle), 32'(!m_active));
    e_last = e_now;
  endtask

  task automatic scan_row(input int yi, input int x_lo, input int x_hi, input bit ri);
    for (int xi = x_lo; xi <= x_hi; xi++) apply_stimulus(xi, yi, 1'b1, ri);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.valid = 1'b0;
    reset     = 1'b0;
    #1;
    check_output("rst_pixel_on", 32'(bus.pixel_on), 32'd0);
    check_output("rst_valid_pixel", 32'(bus.valid_pixel), 32'd0);
    check_output("rst_idle", 32'(bus.wave_display_idle), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int r;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    model_reset();
    bus.x          = 11'd600;
    bus.y          = 10'd10;
    bus.valid      = 1'b1;
    bus.read_index = 1'b0;

    repeat (3) @(negedge clk);
    check_output("hold_pixel_on", 32'(bus.pixel_on), 32'd0);
    check_output("hold_valid_pixel", 32'(bus.valid_pixel), 32'd0);
    check_output("hold_idle", 32'(bus.wave_display_idle), 32'd1);
    bus.valid = 1'b0;
    reset     = 1'b1;

    for (int i = 0; i < 4; i++) apply_stimulus(600 + i, 10, 1'b1, 1'b0);

    apply_stimulus(0, 0, 1'b1, 1'b1);
    apply_stimulus(513, 0, 1'b1, 1'b1);
    apply_stimulus(1022, 0, 1'b1, 1'b1);

    mem[256 + 5] = 8'd40;
    mem[256 + 6] = 8'd60;
    scan_row(100, 512, 530, 1'b1);
    scan_row(130, 512, 530, 1'b1);

    for (int i = 0; i < 512; i++) mem[i] = 8'd127;
    scan_row(254, 508, 1027, 1'b1);
    scan_row(255, 508, 1027, 1'b1);
    scan_row(256, 508, 520, 1'b1);

    apply_stimulus(0, 0, 1'b1, 1'b1);
    scan_row(200, 600, 610, 1'b0);
    apply_stimulus(700, 300, 1'b0, 1'b0);
    apply_stimulus(1023, 511, 1'b1, 1'b0);
    apply_stimulus(700, 5, 1'b1, 1'b0);
    apply_stimulus(0, 0, 1'b1, 1'b0);
    apply_stimulus(700, 5, 1'b1, 1'b1);

    apply_stimulus(576, 10, 1'b1, 1'b0);
    apply_stimulus(577, 11, 1'b1, 1'b0);
    apply_stimulus(600, 64, 1'b1, 1'b0);

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) pulse_reset();
      r = int'($urandom_range(0, 99));
      if (r < 3)
        apply_stimulus(0, 0, 1'b1, 1'($urandom_range(0, 1)));
      else if (r < 6)
        apply_stimulus(1023, 511, 1'b1, 1'($urandom_range(0, 1)));
      else if (r < 60)
        apply_stimulus(int'($urandom_range(512, 1023)), int'($urandom_range(0, 511)),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      else
        apply_stimulus(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
